// File: rtl/ucode_seq_if.sv
// Decoder <-> sequencer feedback bundle: next ROM address and stage controls in,
// executing microword address, branch candidates and sequence status out.
interface ucode_seq_if;
  logic [8:0] rom_addr;
  logic       ucode_in_r;
  logic       hold_e;
  logic       iu_flush_e;
  logic       u_f_done;
  logic [8:0] u_addr_e;
  logic [8:0] nxt_addr_1;
  logic [8:0] nxt_addr_2;
  logic [8:0] nxt_addr_3;
  logic       u_done_l;
  logic       ucode_busy;
  logic       ucode_err;
  logic [5:0] u_step_cnt;

  modport master (
    output rom_addr, ucode_in_r, hold_e, iu_flush_e, u_f_done,
    input  u_addr_e, nxt_addr_1, nxt_addr_2, nxt_addr_3,
    input  u_done_l, ucode_busy, ucode_err, u_step_cnt
  );

  modport slave (
    input  rom_addr, ucode_in_r, hold_e, iu_flush_e, u_f_done,
    output u_addr_e, nxt_addr_1, nxt_addr_2, nxt_addr_3,
    output u_done_l, ucode_busy, ucode_err, u_step_cnt
  );
endinterface

// File: rtl/ucode_seq.sv
// E-stage microcode sequencer: registers the executing microword address, owns the
// IDLE/RUN/ERR sequence state with a step watchdog, and feeds the decoder's done input.
module ucode_seq #(
  parameter int MAX_STEPS = 63
) (
  input logic       clk,
  input logic       reset_l,
  ucode_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] ERR  = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [8:0] addr;
  logic [8:0] addr_nxt;
  logic [5:0] cnt;
  logic [5:0] cnt_nxt;
  logic       advance;

  assign advance = ~bus.hold_e;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
      addr  <= 9'd0;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flush outranks hold; the watchdog freezes the address of the last issued word.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (advance && bus.ucode_in_r) begin
          state_nxt = RUN;
          addr_nxt  = bus.rom_addr;
          cnt_nxt   = 6'd1;
        end
      end
      RUN: begin
        if (bus.iu_flush_e) begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end else if (advance) begin
          if (bus.u_f_done) begin
            if (bus.ucode_in_r) begin
              addr_nxt = bus.rom_addr;
              cnt_nxt  = 6'd1;
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = 6'd0;
            end
          end else if (cnt == 6'(MAX_STEPS)) begin
            state_nxt = ERR;
          end else begin
            addr_nxt = bus.rom_addr;
            cnt_nxt  = cnt + 6'd1;
          end
        end
      end
      ERR: begin
        if (bus.iu_flush_e) begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 6'd0;
      end
    endcase
  end

  // Outputs depend only on registered state and u_f_done, keeping the decoder loop acyclic.
  always_comb begin
    bus.u_addr_e   = addr;
    bus.nxt_addr_1 = addr + 9'd1;
    bus.nxt_addr_2 = addr + 9'd2;
    bus.nxt_addr_3 = addr + 9'd3;
    bus.u_step_cnt = cnt;
    bus.ucode_busy = (state == RUN);
    bus.ucode_err  = (state == ERR);
    bus.u_done_l   = (state == RUN) ? ~bus.u_f_done : 1'b0;
  end

endmodule

// File: tb/tb_ucode_seq.sv
// Directed test-plan steps followed by random traffic, all checked against a
// flag-based behavioural model of the sequence rules.
module tb_ucode_seq;

  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  ucode_seq_if bus ();

  ucode_seq #(.MAX_STEPS(MAXS)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: is a sequence active, has the watchdog tripped, current word, words issued.
  bit m_active;
  bit m_tripped;
  int m_addr;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_tripped = 1'b0;
    m_addr    = 0;
    m_cnt     = 0;
  endtask

  task automatic model_clock(input bit in_r, input int rom, input bit hold, input bit flush,
                             input bit fdone);
    if (m_tripped) begin
      if (flush) begin m_tripped = 1'b0; m_cnt = 0; end
    end else if (m_active) begin
      if (flush) begin
        m_active = 1'b0; m_cnt = 0;
      end else if (!hold) begin
        if (fdone && in_r) begin m_addr = rom; m_cnt = 1; end
        else if (fdone) begin m_active = 1'b0; m_cnt = 0; end
        else if (m_cnt >= MAXS) begin m_active = 1'b0; m_tripped = 1'b1; end
        else begin m_addr = rom; m_cnt = m_cnt + 1; end
      end
    end else if (!hold && in_r) begin
      m_active = 1'b1; m_addr = rom; m_cnt = 1;
    end
  endtask

  function automatic logic exp_done_l(input bit fdone);
    return (m_active && !fdone) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_outs(input string where);
    chk({where, ":u_addr_e"},   32'(bus.u_addr_e),   32'(m_addr));
    chk({where, ":nxt_addr_1"}, 32'(bus.nxt_addr_1), 32'((m_addr + 1) % 512));
    chk({where, ":nxt_addr_2"}, 32'(bus.nxt_addr_2), 32'((m_addr + 2) % 512));
    chk({where, ":nxt_addr_3"}, 32'(bus.nxt_addr_3), 32'((m_addr + 3) % 512));
    chk({where, ":u_step_cnt"}, 32'(bus.u_step_cnt), 32'(m_cnt));
    chk({where, ":ucode_busy"}, 32'(bus.ucode_busy), 32'(m_active));
    chk({where, ":ucode_err"},  32'(bus.ucode_err),  32'(m_tripped));
    chk({where, ":u_done_l"},   32'(bus.u_done_l),   32'(exp_done_l(bus.u_f_done)));
  endtask

  task automatic drive(input bit in_r, input int rom, input bit hold, input bit flush,
                       input bit fdone);
    bus.ucode_in_r = in_r;
    bus.rom_addr   = 9'(rom);
    bus.hold_e     = hold;
    bus.iu_flush_e = flush;
    bus.u_f_done   = fdone;
  endtask

  // One clock: drive, check the combinational done path, clock, check registered state.
  task automatic step(input string tag, input bit in_r, input int rom, input bit hold,
                      input bit flush, input bit fdone);
    drive(in_r, rom, hold, flush, fdone);
    #1;
    chk({tag, ":pre_done_l"}, 32'(bus.u_done_l), 32'(exp_done_l(fdone)));
    @(posedge clk);
    model_clock(in_r, rom, hold, flush, fdone);
    #1;
    check_outs(tag);
  endtask

  initial begin
    reset_l = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_outs("reset");
    chk("reset:nxt3_const", 32'(bus.nxt_addr_3), 32'd3);
    @(posedge clk); #1;
    reset_l = 1'b1;

    // Simple three-word sequence.
    step("seq_w1", 1, 'h040, 0, 0, 0);
    chk("seq_w1:addr_const", 32'(bus.u_addr_e), 32'h040);
    chk("seq_w1:done_l_const", 32'(bus.u_done_l), 32'd1);
    step("seq_w2", 0, 'h041, 0, 0, 0);
    step("seq_w3", 0, 'h042, 0, 0, 0);
    chk("seq_w3:cnt_const", 32'(bus.u_step_cnt), 32'd3);
    step("seq_end", 0, 'h000, 0, 0, 1);
    chk("seq_end:busy_const", 32'(bus.ucode_busy), 32'd0);

    // Address wrap.
    step("wrap", 1, 'h1FF, 0, 0, 0);
    chk("wrap:nxt1_const", 32'(bus.nxt_addr_1), 32'h000);
    chk("wrap:nxt3_const", 32'(bus.nxt_addr_3), 32'h002);
    step("wrap_end", 0, 'h000, 0, 0, 1);

    // Hold during word 2.
    step("hold_w1", 1, 'h080, 0, 0, 0);
    step("hold_w2", 0, 'h081, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("hold_on", 0, 'h082, 1, 0, 0);
      chk("hold_on:addr_const", 32'(bus.u_addr_e), 32'h081);
    end
    step("hold_rel", 0, 'h082, 0, 0, 0);
    chk("hold_rel:addr_const", 32'(bus.u_addr_e), 32'h082);
    step("hold_done_held", 0, 'h000, 1, 0, 1);
    step("hold_end", 0, 'h000, 0, 0, 1);

    // Back-to-back start, then flush together with hold.
    step("b2b_w1", 1, 'h100, 0, 0, 0);
    step("b2b_restart", 1, 'h120, 0, 0, 1);
    chk("b2b:addr_const", 32'(bus.u_addr_e), 32'h120);
    step("flush_hold", 0, 'h121, 1, 1, 0);
    chk("flush_hold:busy_const", 32'(bus.ucode_busy), 32'd0);

    // Watchdog.
    step("wd_w1", 1, 'h010, 0, 0, 0);
    step("wd_w2", 0, 'h011, 0, 0, 0);
    step("wd_w3", 0, 'h012, 0, 0, 0);
    step("wd_w4", 0, 'h013, 0, 0, 0);
    step("wd_trip", 0, 'h014, 0, 0, 0);
    chk("wd_trip:err_const", 32'(bus.ucode_err), 32'd1);
    chk("wd_trip:cnt_const", 32'(bus.u_step_cnt), 32'd4);
    step("wd_ignore1", 1, 'h055, 0, 0, 0);
    step("wd_ignore2", 1, 'h056, 0, 0, 1);
    step("wd_flush", 0, 'h000, 0, 1, 0);
    chk("wd_flush:cnt_const", 32'(bus.u_step_cnt), 32'd0);

    // Asynchronous reset mid-run.
    step("ar_w1", 1, 'h030, 0, 0, 0);
    step("ar_w2", 0, 'h031, 0, 0, 0);
    step("ar_w3", 0, 'h032, 0, 0, 0);
    step("ar_w4", 0, 'h033, 0, 0, 0);
    #2;
    reset_l = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    @(posedge clk); #1;
    reset_l = 1'b1;
    step("post_rst", 0, 'h044, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 511)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ucode_seq.md
# ucode_seq

Microcode sequencer that consumes the ROM address produced by the microcode address decoder (`ucode_add`) and drives that decoder's feedback inputs. It registers the executing microword address, generates the +1/+2/+3 branch candidates, and owns the sequence state: idle, running, or watchdog error. It produces the active-low done indication that makes the decoder choose between a fresh R-stage start address and the computed next address. It sits in the E-stage, between the decoder's `rom_addr` output and the microcode ROM.

## Interface
- `MAX_STEPS`, default 63: microwords allowed per sequence before the watchdog fires; legal range 2..63.
- `clk  in  1`: core clock.
- `reset_l  in  1`: asynchronous, active-low reset.
- `rom_addr  in  9`: next ROM address from the decoder (start address or computed next address).
- `ucode_in_r  in  1`: R-stage opcode requires microcode, including the IU trap.
- `hold_e  in  1`: E-stage stall; freezes all state.
- `iu_flush_e  in  1`: abort the current sequence.
- `u_f_done  in  1`: done bit of the ROM word at `u_addr_e`, valid in the same cycle.
- `u_addr_e  out  9`: registered address of the executing microword, which also drives the ROM read address.
- `nxt_addr_1`, `nxt_addr_2`, `nxt_addr_3`  out  9 each: `u_addr_e` + 1, + 2, + 3, modulo 512.
- `u_done_l  out  1`: low when the decoder should take the R-stage start address.
- `ucode_busy  out  1`: a sequence is executing (state RUN).
- `ucode_err  out  1`: the watchdog fired (state ERR).
- `u_step_cnt  out  6`: microwords issued in the current sequence.

## Operation
States are IDLE, RUN and ERR. A cycle "advances" when `hold_e`=0. `iu_flush_e` takes priority over `hold_e`.

- **IDLE**
  - `u_done_l`=0.
  - On advance with `ucode_in_r`=1: `u_addr_e`<=`rom_addr`, `u_step_cnt`<=1, go to RUN.
  - Otherwise hold state.
- **RUN**
  - `u_done_l` = ~`u_f_done`; `ucode_busy`=1.
  - `iu_flush_e`=1: go to IDLE, `u_step_cnt`<=0. `u_addr_e` keeps its value.
  - `hold_e`=1 (no flush): nothing changes.
  - Advance with `u_f_done`=1 and `ucode_in_r`=1: back-to-back start. `u_addr_e`<=`rom_addr`, `u_step_cnt`<=1, stay in RUN.
  - Advance with `u_f_done`=1 and `ucode_in_r`=0: go to IDLE, `u_step_cnt`<=0.
  - Advance with `u_f_done`=0:
    - If `u_step_cnt`==`MAX_STEPS`: go to ERR. `u_addr_e` is frozen.
    - Else: `u_addr_e`<=`rom_addr`, `u_step_cnt`<=`u_step_cnt`+1.
- **ERR**
  - `ucode_err`=1, `u_done_l`=0, `ucode_busy`=0.
  - Leave only on `iu_flush_e`=1: go to IDLE, `u_step_cnt`<=0.
  - `ucode_in_r` is ignored.
- **Arithmetic:** the `nxt_addr_*` outputs are 9-bit adds with carry-out dropped, so 0x1FF+1 = 0x000.
- **Done and done-path:** the done bit is taken from `u_f_done` only in RUN. An unused state encoding recovers to IDLE on the next clock.

## Timing
- **Reset values** (asynchronous, while `reset_l`=0):
  - State IDLE.
  - `u_addr_e`=0, `u_step_cnt`=0.
  - `nxt_addr_1/2/3` = 1/2/3.
  - `u_done_l`=0, `ucode_busy`=0, `ucode_err`=0.
- **Registered outputs:** `u_addr_e`, `u_step_cnt`, and state-derived `ucode_busy` / `ucode_err` are registered.
- **Combinational outputs:** `nxt_addr_*` come from `u_addr_e` alone. `u_done_l` comes from the state and `u_f_done` only. There is no combinational path from `rom_addr`, `ucode_in_r` or `hold_e` to any output, so the decoder loop through `u_done_l` is acyclic.
- **Latency:** 1 cycle from an accepted start (`rom_addr` sampled) to `u_addr_e` valid. A sequence of N words occupies exactly N advancing cycles in RUN.
- **Reset deassertion mid-sequence:** the first edge after `reset_l` rises behaves as IDLE.
- **Hold on the done cycle:** with `hold_e`=1 on a `u_f_done`=1 cycle, `u_done_l` stays 0 for the whole hold and the transition happens on the first advancing cycle.

## Test plan
- **Simple sequence:** reset, then `ucode_in_r`=1, `rom_addr`=0x040; feed 0x041, 0x042 with `u_f_done`=1 on word 3.
  - `u_addr_e` = 0x040, 0x041, 0x042; `u_step_cnt` = 1, 2, 3; `u_done_l` = 1, 1, 0.
  - Then IDLE with `ucode_busy`=0.
- **Wrap:** start at 0x1FF.
  - `nxt_addr_1/2/3` = 0x000 / 0x001 / 0x002.
- **Hold:** `hold_e`=1 for 3 cycles during word 2 of a run at 0x080.
  - `u_addr_e` stays 0x081 and `u_step_cnt` stays 2 for those 3 cycles.
  - On release the run resumes at 0x082.
- **Back-to-back and flush priority:**
  - Done word with `ucode_in_r`=1, `rom_addr`=0x120: next cycle `u_addr_e`=0x120, `u_step_cnt`=1, RUN.
  - Later, `iu_flush_e`=1 together with `hold_e`=1: IDLE next cycle.
- **Watchdog** (`MAX_STEPS`=4, `u_f_done` never set):
  - After the 4th word, ERR: `ucode_err`=1, `u_done_l`=0, `u_step_cnt`=4.
  - `ucode_in_r` pulses are ignored.
  - `iu_flush_e` returns to IDLE with `u_step_cnt`=0.
- **Asynchronous reset mid-RUN** (at `u_addr_e`=0x033): all outputs take their reset values without waiting for a clock edge.
